// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the WM8731 DAC path, with the codec as slave.
// BCLK runs at clk/2. Serial state changes only when BCLK falls, so the codec
// sees stable data on its rising edge. A single-entry buffer holds the next
// stereo pair. An empty buffer at frame load sends silence and pulses underrun.
module i2s_dac_tx #(
  parameter int SLOT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SLOT_W-1:0] sample_l,
  input  logic [SLOT_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              underrun,
  output logic              i2s_bclk,
  output logic              i2s_lrc,
  output logic              i2s_dat
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(SLOT_W);

  // Registered state
  logic               bclk_reg;
  logic               lrc_reg;
  logic               dat_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [FRAME_W-1:0] sreg_reg;
  logic [SLOT_W-1:0]  buf_l_reg;
  logic [SLOT_W-1:0]  buf_r_reg;
  logic               buf_full_reg;
  logic               ready_reg;
  logic               underrun_reg;

  // Next-state values
  logic               lrc_next;
  logic               dat_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [FRAME_W-1:0] sreg_next;
  logic               buf_full_next;
  logic               underrun_next;

  logic               fall;
  logic               load;
  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic [FRAME_W-1:0] sreg_shift;

  // The shift register moves toward the MSB and fills with zero.
  assign sreg_shift[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < FRAME_W; gi++) begin : g_shift
      assign sreg_shift[gi] = sreg_reg[gi-1];
    end
  endgenerate

  // BCLK is high during the cycle before a falling edge.
  assign fall    = bclk_reg;
  assign cnt_inc = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
  assign load    = fall && (cnt_inc == '0);
  assign accept  = sample_valid && ready_reg;

  // Serial and buffer next-state logic.
  always_comb begin
    lrc_next      = lrc_reg;
    dat_next      = dat_reg;
    cnt_next      = cnt_reg;
    sreg_next     = sreg_reg;
    buf_full_next = buf_full_reg;
    underrun_next = 1'b0;

    if (fall) begin
      cnt_next = cnt_inc;
      dat_next = sreg_reg[FRAME_W-1];
      if (load) begin
        lrc_next      = 1'b0;
        sreg_next     = buf_full_reg ? {buf_l_reg, buf_r_reg} : '0;
        underrun_next = !buf_full_reg;
        buf_full_next = 1'b0;
      end else begin
        sreg_next = sreg_shift;
        if (cnt_inc == CNT_RIGHT) begin
          lrc_next = 1'b1;
        end
      end
    end

    // A pair accepted on a load edge is kept for the following frame.
    if (accept) begin
      buf_full_next = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_reg     <= 1'b0;
      lrc_reg      <= 1'b1;
      dat_reg      <= 1'b0;
      cnt_reg      <= CNT_MAX;
      sreg_reg     <= '0;
      buf_l_reg    <= '0;
      buf_r_reg    <= '0;
      buf_full_reg <= 1'b0;
      ready_reg    <= 1'b1;
      underrun_reg <= 1'b0;
    end else begin
      bclk_reg     <= ~bclk_reg;
      lrc_reg      <= lrc_next;
      dat_reg      <= dat_next;
      cnt_reg      <= cnt_next;
      sreg_reg     <= sreg_next;
      buf_full_reg <= buf_full_next;
      ready_reg    <= ~buf_full_next;
      underrun_reg <= underrun_next;
      if (accept) begin
        buf_l_reg <= sample_l;
        buf_r_reg <= sample_r;
      end
    end
  end

  assign sample_ready = ready_reg;
  assign underrun     = underrun_reg;
  assign i2s_bclk     = bclk_reg;
  assign i2s_lrc      = lrc_reg;
  assign i2s_dat      = dat_reg;

endmodule
